bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width of master and slave buses.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameters MEM_BASE/MEM_END (0x0000_0000/0x0000_07FF), TIM_BASE/TIM_END (0x0000_1000/0x0000_100F), UART_BASE/UART_END (0x0000_1010/0x0000_101F), all inclusive byte ranges.
REQ-004 SHALL have parameter MAX_LOCK, default 8, maximum consecutive locked grants while the other master waits.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 m0_req/m1_req  input  1  master requests one bus transfer this cycle (m0 = core, m1 = DMA/debug).
REQ-008 m0_we/m1_we  input  1  1 = write, 0 = read.
REQ-009 m0_lock/m1_lock  input  1  master asks to keep ownership for its next request.
REQ-010 m0_addr/m1_addr  input  ADDR_W  byte address.
REQ-011 m0_wdata/m1_wdata  input  DATA_W  write data.
REQ-012 m0_gnt/m1_gnt  output  1  transfer accepted this cycle (combinational).
REQ-013 m0_rvalid/m1_rvalid  output  1  read data valid (one-cycle pulse).
REQ-014 m0_err/m1_err  output  1  unmapped-address pulse, same timing as rvalid.
REQ-015 m_rdata  output  DATA_W  read data shared by both masters, qualified by mX_rvalid.
REQ-016 s_r_enable / s_w_enable  output  1  slave read / write strobe.
REQ-017 s_addr  output  ADDR_W  winning address; s_wdata  output  DATA_W  winning write data.
REQ-018 sel_mem/sel_tim/sel_uart  output  1  one-hot slave select for the current transfer.
REQ-019 mem_rdata/tim_rdata/uart_rdata  input  DATA_W  slave read data, valid one cycle after a read strobe.

Function
REQ-020 SHALL grant at most one master per cycle; m0_gnt & m1_gnt never both 1.
REQ-021 Single requester SHALL be granted the same cycle it requests.
REQ-022 Both requesting, no lock held: round-robin; the master not granted last wins; pointer updates only on a grant.
REQ-023 Lock: if the master granted last cycle had mX_lock=1 and requests again, it SHALL win regardless of the pointer.
REQ-024 lock_cnt SHALL count consecutive locked grants while the other master requests; when lock_cnt reaches MAX_LOCK, the next contended cycle SHALL go to the other master, and lock_cnt clears.
REQ-025 lock_cnt SHALL clear on any grant switch or any cycle with no grant; it SHALL saturate, never wrap.
REQ-026 Decode: address in [MEM_BASE,MEM_END] -> sel_mem, [TIM_BASE,TIM_END] -> sel_tim, [UART_BASE,UART_END] -> sel_uart; ranges never overlap.
REQ-027 Unmapped address SHALL still be granted, with all sel_* = 0 and both strobes = 0 (write dropped).
REQ-028 s_w_enable = gnt & we & mapped; s_r_enable = gnt & ~we & mapped; s_addr/s_wdata follow winner, 0 when idle.
REQ-029 A granted read SHALL register owner, slave select and mapped flag; next cycle pulse the owner's rvalid (mapped) or err (unmapped).
REQ-030 m_rdata SHALL mux the registered slave select: mem/tim/uart rdata; 0 for err or no read pending.
REQ-031 Back-to-back reads, including alternating masters, SHALL each return exactly one cycle later at full throughput.
REQ-032 Writes SHALL produce no rvalid; unmapped writes SHALL pulse err one cycle later.
REQ-033 Request without gnt SHALL be held by the master; the arbiter keeps no request queue.

Reset
REQ-034 While rst_n=0: pointer = m1-last (m0 wins first tie), lock_cnt = 0, read-pending registers = 0, all rvalid/err = 0, m_rdata = 0.
REQ-035 Combinational outputs during reset SHALL be 0 (gnt, strobes, sel_*); a read pending at reset assertion SHALL be discarded with no rvalid after release.

Verification
REQ-036 Both request reads at 0x10 and 0x20 out of reset -> cycle 0 m0_gnt; cycle 1 m1_gnt and m0_rvalid with mem word 0x10; cycle 2 m1_rvalid.
REQ-037 Both hold req continuously, no lock -> grants alternate m0,m1,m0,m1.
REQ-038 m1 locks continuously with m0 requesting, MAX_LOCK=8 -> m1 gets exactly 8 consecutive grants, then m0 granted.
REQ-039 m0 read 0x1004 then m0 write 0x1010 data 0x41 -> sel_tim read, rvalid with tim_rdata; then sel_uart, s_w_enable=1, s_wdata=0x41.
REQ-040 m1 read 0x8000 -> m1_gnt, no strobe or sel; next cycle m1_err=1, m_rdata=0, m1_rvalid=0.
REQ-041 rst_n low the cycle after a granted read -> no rvalid/err after release; first contended grant is m0.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Two-master, three-slave bus arbiter with address decode and a one-cycle
//   registered read-response path. Master 0 is the core and master 1 is the
//   DMA/debug port. Arbitration is round-robin. A master that holds its lock
//   request keeps the bus, but only for MAX_LOCK contended grants in a row.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   mX_req/we/lock/addr/wdata       master request channel (X = 0, 1)
//   mX_gnt                          combinational accept for this cycle
//   mX_rvalid, mX_err               one-cycle response pulses, next cycle
//   m_rdata                         shared read data, qualified by mX_rvalid
//   s_r_enable, s_w_enable          slave read / write strobes
//   s_addr, s_wdata                 winning master's address / write data
//   sel_mem, sel_tim, sel_uart      one-hot slave select for this transfer
//   mem_rdata, tim_rdata, uart_rdata  slave read data, one cycle after strobe

module bus_arbiter #(
  parameter int                 ADDR_W    = 32,
  parameter int                 DATA_W    = 32,
  parameter logic [ADDR_W-1:0]  MEM_BASE  = 'h0000_0000,
  parameter logic [ADDR_W-1:0]  MEM_END   = 'h0000_07FF,
  parameter logic [ADDR_W-1:0]  TIM_BASE  = 'h0000_1000,
  parameter logic [ADDR_W-1:0]  TIM_END   = 'h0000_100F,
  parameter logic [ADDR_W-1:0]  UART_BASE = 'h0000_1010,
  parameter logic [ADDR_W-1:0]  UART_END  = 'h0000_101F,
  parameter int                 MAX_LOCK  = 8
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic              m0_err,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic              m1_err,

  output logic [DATA_W-1:0] m_rdata,

  output logic              s_r_enable,
  output logic              s_w_enable,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic              sel_mem,
  output logic              sel_tim,
  output logic              sel_uart,

  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] tim_rdata,
  input  logic [DATA_W-1:0] uart_rdata
);

  localparam int CNT_W = (MAX_LOCK < 1) ? 1 : $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(MAX_LOCK);

  // Range check done as an offset compare so a base of zero needs no
  // special case: (a - lo) wraps to a large value when a < lo.
  function automatic logic in_range(input logic [ADDR_W-1:0] a,
                                    input logic [ADDR_W-1:0] lo,
                                    input logic [ADDR_W-1:0] hi);
    logic [ADDR_W-1:0] off;
    off = a - lo;
    return off <= (hi - lo);
  endfunction

  // Arbitration state: who won last, whether that winner asked to keep
  // the bus, and how many locked grants the other master has sat through.
  logic             last_m1;
  logic             lock_held;
  logic [CNT_W-1:0] lock_cnt;

  logic              both_req;
  logic              lock_force;
  logic              win_m1;
  logic              any_gnt;
  logic              win_we;
  logic              win_lock;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              hit_mem;
  logic              hit_tim;
  logic              hit_uart;
  logic              mapped;

  // Registered response state for the transfer granted last cycle.
  logic       rv0_q;
  logic       rv1_q;
  logic       err0_q;
  logic       err1_q;
  logic [2:0] rsel_q;

  // Winner selection. Under contention the lock holder keeps the bus while
  // its budget lasts; otherwise the master that did not win last goes.
  // Grants are forced low while reset is asserted.
  always_comb begin
    both_req   = m0_req & m1_req;
    lock_force = lock_held & (lock_cnt < LOCK_LIMIT);
    if (both_req) begin
      win_m1 = lock_force ? last_m1 : ~last_m1;
    end else begin
      win_m1 = m1_req;
    end
    m1_gnt  = rst_n & m1_req & win_m1;
    m0_gnt  = rst_n & m0_req & ~win_m1;
    any_gnt = m0_gnt | m1_gnt;
  end

  // Forward the winning request; everything reads as zero when idle.
  always_comb begin
    win_we    = 1'b0;
    win_lock  = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    if (m1_gnt) begin
      win_we    = m1_we;
      win_lock  = m1_lock;
      win_addr  = m1_addr;
      win_wdata = m1_wdata;
    end else if (m0_gnt) begin
      win_we    = m0_we;
      win_lock  = m0_lock;
      win_addr  = m0_addr;
      win_wdata = m0_wdata;
    end
  end

  // Address decode is qualified by the grant, since an idle bus drives
  // address zero which would otherwise decode as memory.
  always_comb begin
    hit_mem    = any_gnt & in_range(win_addr, MEM_BASE, MEM_END);
    hit_tim    = any_gnt & in_range(win_addr, TIM_BASE, TIM_END);
    hit_uart   = any_gnt & in_range(win_addr, UART_BASE, UART_END);
    mapped     = hit_mem | hit_tim | hit_uart;
    sel_mem    = hit_mem;
    sel_tim    = hit_tim;
    sel_uart   = hit_uart;
    s_r_enable = mapped & ~win_we;
    s_w_enable = mapped & win_we;
    s_addr     = win_addr;
    s_wdata    = win_wdata;
  end

  // lock_cnt only advances when the same master wins a contended cycle,
  // which can only happen through the lock. The limit forces a switch,
  // and that switch clears the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_m1   <= 1'b1;
      lock_held <= 1'b0;
      lock_cnt  <= '0;
    end else if (!any_gnt) begin
      lock_held <= 1'b0;
      lock_cnt  <= '0;
    end else begin
      last_m1   <= m1_gnt;
      lock_held <= win_lock;
      if (m1_gnt != last_m1) begin
        lock_cnt <= '0;
      end else if (both_req && (lock_cnt < LOCK_LIMIT)) begin
        lock_cnt <= lock_cnt + CNT_W'(1);
      end
    end
  end

  // Capture the owner and slave select of this cycle's transfer so the
  // response comes back exactly one cycle later. Unmapped accesses,
  // whether read or write, answer with err instead of rvalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv0_q  <= 1'b0;
      rv1_q  <= 1'b0;
      err0_q <= 1'b0;
      err1_q <= 1'b0;
      rsel_q <= 3'b000;
    end else begin
      rv0_q  <= m0_gnt & s_r_enable;
      rv1_q  <= m1_gnt & s_r_enable;
      err0_q <= m0_gnt & ~mapped;
      err1_q <= m1_gnt & ~mapped;
      rsel_q <= s_r_enable ? {hit_uart, hit_tim, hit_mem} : 3'b000;
    end
  end

  assign m0_rvalid = rv0_q;
  assign m1_rvalid = rv1_q;
  assign m0_err    = err0_q;
  assign m1_err    = err1_q;

  always_comb begin
    case (rsel_q)
      3'b001:  m_rdata = mem_rdata;
      3'b010:  m_rdata = tim_rdata;
      3'b100:  m_rdata = uart_rdata;
      default: m_rdata = '0;
    endcase
  end

endmodule
